// File: rtl/vram_write_arbiter_if.sv
// VRAM write-arbiter bus: CPU write handshake, fill control and the VRAM write port.
interface vram_write_arbiter_if;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        fill_start;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;

    modport master (
        output cpu_req, cpu_addr, cpu_data, fill_start, fill_data,
        input  cpu_ack, fill_busy, fill_done, ram_ce, ram_addr, ram_data
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_data, fill_start, fill_data,
        output cpu_ack, fill_busy, fill_done, ram_ce, ram_addr, ram_data
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// Arbitrates CPU cell writes and whole-screen fills onto a single VRAM write port,
// optionally restricted to a vblank window opened by frame_int.
module vram_write_arbiter #(
    parameter int CELLS      = 750,
    parameter int WIN_GATE   = 0,
    parameter int WIN_CYCLES = 4096
) (
    input  logic                 clk_pix,
    input  logic                 reset,
    input  logic                 frame_int,
    vram_write_arbiter_if.slave  bus
);
    localparam int              WW       = $clog2(WIN_CYCLES + 1);
    localparam logic [11:0]     CELLS_W  = 12'(CELLS);
    localparam logic [WW-1:0]   WIN_LOAD = WW'(WIN_CYCLES);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state, state_d;
    logic          frame_q;
    logic [WW-1:0] win_cnt;
    logic          gate_open;
    logic [11:0]   fill_cnt;
    logic [15:0]   fill_val;
    logic          last_cpu;
    logic          cpu_ok, cpu_issue, fill_issue, fill_accept, finish;

    assign gate_open = (WIN_GATE == 0) || (win_cnt != '0);

    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // A request seen while cpu_ack is high is the tail of the write just issued.
    always_comb begin
        state_d     = state;
        cpu_issue   = 1'b0;
        fill_issue  = 1'b0;
        fill_accept = 1'b0;
        finish      = 1'b0;
        cpu_ok      = bus.cpu_req && gate_open && !bus.cpu_ack;
        case (state)
            IDLE: begin
                cpu_issue = cpu_ok;
                if (bus.fill_start) begin
                    fill_accept = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (fill_cnt == CELLS_W) begin
                    finish    = 1'b1;
                    state_d   = IDLE;
                    cpu_issue = cpu_ok && !last_cpu;
                end else if (gate_open) begin
                    cpu_issue  = cpu_ok && !last_cpu;
                    fill_issue = !cpu_issue;
                end
            end
        endcase
    end

    always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) begin
            frame_q       <= 1'b0;
            win_cnt       <= '0;
            fill_cnt      <= '0;
            fill_val      <= '0;
            last_cpu      <= 1'b0;
            bus.ram_ce    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_data  <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.fill_busy <= 1'b0;
            bus.fill_done <= 1'b0;
        end else begin
            frame_q <= frame_int;
            if (frame_int && !frame_q)
                win_cnt <= WIN_LOAD;
            else if (win_cnt != '0)
                win_cnt <= win_cnt - WW'(1);

            if (fill_accept) begin
                fill_val <= bus.fill_data;
                fill_cnt <= '0;
            end else if (fill_issue) begin
                fill_cnt <= fill_cnt + 12'd1;
            end

            // Alternation memory survives a closed gate; outside a fill it only tracks the last slot.
            if (cpu_issue || fill_issue)
                last_cpu <= cpu_issue;
            else if (state == IDLE)
                last_cpu <= 1'b0;

            bus.ram_ce  <= cpu_issue || fill_issue;
            bus.cpu_ack <= cpu_issue;
            if (cpu_issue) begin
                bus.ram_addr <= bus.cpu_addr;
                bus.ram_data <= bus.cpu_data;
            end else if (fill_issue) begin
                bus.ram_addr <= fill_cnt;
                bus.ram_data <= fill_val;
            end

            bus.fill_busy <= (state_d == FILL);
            bus.fill_done <= finish;
        end
    end
endmodule

// File: doc/vram_write_arbiter.md
VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameter CELLS, default 750, text cells in VRAM (50 cols x 15 rows).
REQ-002 Parameter WIN_GATE, default 0, 1 = writes only inside vblank window.
REQ-003 Parameter WIN_CYCLES, default 4096, window length in clk_pix cycles.
REQ-004 clk_pix  in  1  pixel clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 frame_int  in  1  frame interrupt level from display timing, clk_pix domain.
REQ-007 cpu_req  in  1  CPU write request, held until cpu_ack.
REQ-008 cpu_addr  in  12  CPU cell address.
REQ-009 cpu_data  in  16  CPU cell data {bg[3:0],fg[3:0],unused,char[6:0]}.
REQ-010 cpu_ack  out  1  one-cycle pulse: CPU write issued this cycle.
REQ-011 fill_start  in  1  pulse: start whole-screen fill.
REQ-012 fill_data  in  16  fill cell value, sampled on accepted fill_start.
REQ-013 fill_busy  out  1  fill in progress.
REQ-014 fill_done  out  1  one-cycle pulse: fill complete.
REQ-015 ram_ce  out  1  VRAM write-port enable, one cycle per write.
REQ-016 ram_addr  out  12  VRAM write address.
REQ-017 ram_data  out  16  VRAM write data.

Function
REQ-018 All outputs SHALL be registered; ram_addr/ram_data SHALL be valid in every cycle ram_ce=1.
REQ-019 At most one write SHALL issue per cycle.
REQ-020 Gate open: WIN_GATE=0 -> always; WIN_GATE=1 -> from cycle after frame_int rising edge for exactly WIN_CYCLES cycles (down-counter); rising edge while open reloads counter.
REQ-021 States: IDLE, FILL; in IDLE with cpu_req=1 and gate open, ram_ce/cpu_ack/ram_addr=cpu_addr/ram_data=cpu_data SHALL assert next cycle (latency 1).
REQ-022 cpu_req SHALL be ignored in the cycle cpu_ack=1 (max one CPU write per 2 cycles); a request is never dropped, only stalled.
REQ-023 fill_start in IDLE SHALL latch fill_data, clear fill counter, enter FILL; fill_busy=1 next cycle.
REQ-024 fill_start while FILL SHALL be ignored (no restart, no data relatch).
REQ-025 fill_start and cpu_req in same IDLE cycle: CPU write issues first, FILL entered same edge.
REQ-026 FILL, gate open: each cycle issues one write; fill write uses address=counter, data=latched value, counter+1 after issue.
REQ-027 FILL with cpu_req pending: slots SHALL alternate CPU, fill, CPU, fill; CPU takes a slot only when previous issued slot was fill or none.
REQ-028 Gate closed: no writes; counter, latched data, alternation state held; resumes at same address when gate reopens.
REQ-029 After write to address CELLS-1: next cycle fill_busy=0, fill_done=1 for one cycle, state IDLE.
REQ-030 cpu_addr passed unmodified; no range check (addresses >= CELLS written as given).
REQ-031 ram_ce=0 implies cpu_ack=0; cpu_ack=1 implies ram_ce=1.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, ram_ce=0, ram_addr=0, ram_data=0, cpu_ack=0, fill_busy=0, fill_done=0, counters=0, window closed.
REQ-033 Reset mid-fill SHALL abort fill; no fill_done issued; after release fill_start required to restart.

Verification
REQ-034 WIN_GATE=0, cpu_req with addr 0x012 data 0x1F41 -> next cycle ram_ce=1, cpu_ack=1, ram_addr=0x012, ram_data=0x1F41; single pulse.
REQ-035 fill_start, fill_data 0x0020, no CPU -> 750 consecutive writes addr 0..749, then fill_busy=0, fill_done one cycle.
REQ-036 cpu_req held during fill at counter 100 -> writes: fill 100, CPU, fill 101; fill total still 750 cells, done delayed by 1 cycle.
REQ-037 WIN_GATE=1, WIN_CYCLES=16, fill started -> exactly 16 writes per frame_int edge, addresses continuous across windows, no writes when closed.
REQ-038 reset asserted at counter 300 -> all outputs 0 immediately; no fill_done; new fill_start restarts at addr 0.
REQ-039 fill_start pulsed again at counter 50 with new data -> ignored; addr 50 onward keeps original data.
